// File: rtl/msg_rom_streamer_if.sv
// Valid/ready character stream between msg_rom_streamer (master) and a character sink (slave).
interface msg_rom_streamer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/msg_rom_streamer.sv
// Message ROM with a sequencer streaming one character per accepted beat, plus a random-access port.
// Optional NUL terminator beat after a non-looping stream is enabled by defining MSG_NUL_TERM_EN.
module msg_rom_streamer #(
    parameter int unsigned          MSG_LEN = 7,
    parameter int unsigned          ADDR_W  = 4,
    parameter logic [MSG_LEN*8-1:0] MSG     = "STUDENT",
    parameter bit                   LOOP    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    msg_rom_streamer_if.master bus
);

`ifdef MSG_NUL_TERM_EN
    typedef enum logic [1:0] {StIdle, StStream, StTerm, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;
`endif

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MSG_LEN - 1);

    // Character 0 is the most significant byte; out-of-range addresses read as NUL.
    function automatic logic [7:0] char_at(input logic [ADDR_W-1:0] addr);
        logic [7:0] c;
        c = 8'h00;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (addr == ADDR_W'(i)) begin
                c = MSG[(MSG_LEN - 1 - i) * 8 +: 8];
            end
        end
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] idx_inc;
    logic              accept;

    assign idx_inc = idx_q + ADDR_W'(1);
    assign accept  = bus.out_valid && bus.out_ready;
    assign rd_data = char_at(rd_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                    idx_d   = '0;
                    data_d  = char_at('0);
                end
            end
            StStream: begin
                // Abort wins over both the wrap and the terminator entry.
                if (abort) begin
                    state_d = StDone;
                    data_d  = 8'h00;
                end else if (accept) begin
                    if (idx_q == LastIdx) begin
                        if (LOOP) begin
                            idx_d  = '0;
                            data_d = char_at('0);
                        end else begin
`ifdef MSG_NUL_TERM_EN
                            state_d = StTerm;
`else
                            state_d = StDone;
`endif
                            data_d  = 8'h00;
                        end
                    end else begin
                        idx_d  = idx_inc;
                        data_d = char_at(idx_inc);
                    end
                end
            end
`ifdef MSG_NUL_TERM_EN
            StTerm: begin
                if (abort || accept) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            StStream: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
`ifdef MSG_NUL_TERM_EN
            StTerm: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
`endif
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        bus.out_data = data_q;
    end

endmodule
